// File: rtl/ma_pkg.sv
// ma_pkg: shared MA handshake types, widths and the source-count clamp
package ma_pkg;
  localparam int MA_DATA_W = 16;
  localparam int MA_ADDR_W = 16;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COPY,
    ST_DRAIN,
    ST_ANSWER,
    ST_RELEASE
  } ma_state_t;
  function automatic logic [31:0] ma_clamp(input logic [31:0] what, input logic [31:0] count,
                                           input logic [31:0] depth);
    return (what >= depth) ? 32'd0 : (count < depth - what) ? count : depth - what;
  endfunction
endpackage

// File: rtl/ma_rd_pipe.sv
// ma_rd_pipe: delays {valid, dst_addr} by the source read latency so it lines up with src_data
module ma_rd_pipe #(
  parameter int ADDR_W   = 16,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_addr
);
  logic [READ_LAT-1:0] r_vld;
  logic [ADDR_W-1:0]   r_addr [READ_LAT];
  // shift one stage per clock; stage READ_LAT-1 meets the returning read data
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_vld <= '0;
      for (int k = 0; k < READ_LAT; k++) r_addr[k] <= '0;
    end else begin
      r_vld[0]  <= i_valid;
      r_addr[0] <= i_addr;
      for (int k = 1; k < READ_LAT; k++) begin
        r_vld[k]  <= r_vld[k-1];
        r_addr[k] <= r_addr[k-1];
      end
    end
  end
  assign o_valid = r_vld[READ_LAT-1];
  assign o_addr  = r_addr[READ_LAT-1];
endmodule

// File: rtl/ma_dump_responder.sv
// ma_dump_responder: copies a clamped block of the data segment to shared memory and answers the MA handshake
module ma_dump_responder
  import ma_pkg::*;
#(
  parameter int DATA_W    = MA_DATA_W,
  parameter int ADDR_W    = MA_ADDR_W,
  parameter int SRC_DEPTH = 1024,
  parameter int READ_LAT  = 1
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              ma_request,
  input  logic [ADDR_W-1:0] MA_WHERE,
  input  logic [ADDR_W-1:0] MA_WHAT,
  input  logic [ADDR_W-1:0] MA_COUNT,
  output logic [DATA_W-1:0] MA_ANSWER,
  output logic              ma_answer,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [DATA_W-1:0] src_data,
  output logic [ADDR_W-1:0] dst_addr,
  output logic [DATA_W-1:0] dst_data,
  output logic              dst_wren,
  output logic              busy
);
  ma_state_t         r_state, w_next;
  logic [ADDR_W-1:0] r_where, r_what, r_n, r_idx, r_drain;
  logic              r_dropped;
  logic [ADDR_W-1:0] w_n_eff;
  logic              w_wr_vld;
  logic [ADDR_W-1:0] w_wr_addr;
  assign w_n_eff = ADDR_W'(ma_clamp(32'(MA_WHAT), 32'(MA_COUNT), 32'(SRC_DEPTH)));
  // next state: copy runs to completion; a request dropped mid-copy skips the answer phase
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (ma_request) w_next = (w_n_eff == '0) ? ST_ANSWER : ST_COPY;
      ST_COPY:    if (r_idx == r_n - ADDR_W'(1)) w_next = ST_DRAIN;
      ST_DRAIN:   if (r_drain == ADDR_W'(READ_LAT - 1))
                    w_next = (r_dropped || !ma_request) ? ST_IDLE : ST_ANSWER;
      ST_ANSWER:  if (!ma_request) w_next = ST_RELEASE;
      ST_RELEASE: w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end
  // state register plus operand latch, issue/drain counters and drop tracking
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state   <= ST_IDLE;
      r_where   <= '0;
      r_what    <= '0;
      r_n       <= '0;
      r_idx     <= '0;
      r_drain   <= '0;
      r_dropped <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && ma_request) begin
        r_where   <= MA_WHERE;
        r_what    <= MA_WHAT;
        r_n       <= w_n_eff;
        r_idx     <= '0;
        r_drain   <= '0;
        r_dropped <= 1'b0;
      end
      if (r_state == ST_COPY) r_idx <= r_idx + ADDR_W'(1);
      if (r_state == ST_DRAIN) r_drain <= r_drain + ADDR_W'(1);
      if ((r_state == ST_COPY || r_state == ST_DRAIN) && !ma_request) r_dropped <= 1'b1;
    end
  end
  ma_rd_pipe #(.ADDR_W(ADDR_W), .READ_LAT(READ_LAT)) u_pipe (
    .clk     (clk),
    .clr_n   (clr_n),
    .i_valid (r_state == ST_COPY),
    .i_addr  (r_where + r_idx),
    .o_valid (w_wr_vld),
    .o_addr  (w_wr_addr)
  );
  assign src_addr  = (r_state == ST_COPY) ? r_what + r_idx : '0;
  assign dst_wren  = w_wr_vld;
  assign dst_addr  = w_wr_vld ? w_wr_addr : '0;
  assign dst_data  = w_wr_vld ? src_data : '0;
  assign ma_answer = (r_state == ST_ANSWER);
  assign MA_ANSWER = (r_state == ST_ANSWER) ? DATA_W'(r_n) : '0;
  assign busy      = (r_state != ST_IDLE);
endmodule

// File: tb/tb_ma_dump_responder.sv
// tb_ma_dump_responder: directed checks of the MA dump responder at read latencies 1 and 3
module tb_ma_dump_responder;
  logic        clk = 1'b0;
  logic        clr_n;
  logic        req, ans, dst_wren, busy;
  logic [15:0] where, what, count, ans_w, src_addr, src_data, dst_addr, dst_data;
  logic        req3, ans3, dst_wren3, busy3;
  logic [15:0] where3, what3, count3, ans_w3, src_addr3, src_data3, dst_addr3, dst_data3;
  logic [15:0] p1, p2;
  logic [15:0] mem [1024];
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  ma_dump_responder #(.READ_LAT(1)) dut (
    .clk(clk), .clr_n(clr_n), .ma_request(req), .MA_WHERE(where), .MA_WHAT(what),
    .MA_COUNT(count), .MA_ANSWER(ans_w), .ma_answer(ans), .src_addr(src_addr),
    .src_data(src_data), .dst_addr(dst_addr), .dst_data(dst_data), .dst_wren(dst_wren),
    .busy(busy)
  );

  ma_dump_responder #(.READ_LAT(3)) dut3 (
    .clk(clk), .clr_n(clr_n), .ma_request(req3), .MA_WHERE(where3), .MA_WHAT(what3),
    .MA_COUNT(count3), .MA_ANSWER(ans_w3), .ma_answer(ans3), .src_addr(src_addr3),
    .src_data(src_data3), .dst_addr(dst_addr3), .dst_data(dst_data3), .dst_wren(dst_wren3),
    .busy(busy3)
  );

  always @(posedge clk) src_data <= mem[src_addr[9:0]];

  always @(posedge clk) begin
    p1 <= mem[src_addr3[9:0]];
    p2 <= p1;
    src_data3 <= p2;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [15:0] wh, input logic [15:0] wt, input logic [15:0] ct);
    where = wh;
    what  = wt;
    count = ct;
    req   = 1'b1;
    tick();
  endtask

  task automatic drop_req;
    req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset;
    clr_n = 1'b0;
    req   = 1'b0;
    req3  = 1'b0;
    where = '0; what = '0; count = '0;
    where3 = '0; what3 = '0; count3 = '0;
    #12;
    vectors++;
    if ({ans, ans_w, src_addr, dst_addr, dst_data, dst_wren, busy} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got ans=%b ans_w=%h src=%h dst=%h data=%h wren=%b busy=%b exp all 0",
               ans, ans_w, src_addr, dst_addr, dst_data, dst_wren, busy);
    end
    vectors++;
    if ({ans3, ans_w3, dst_wren3, busy3} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs3: got ans=%b ans_w=%h wren=%b busy=%b exp all 0",
               ans3, ans_w3, dst_wren3, busy3);
    end
    clr_n = 1'b1;
    tick();
  endtask

  task automatic test_basic;
    logic [15:0] ed [4];
    ed = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
    start(16'h2000, 16'h0010, 16'd4);
    for (int c = 1; c <= 6; c++) begin
      logic ew;
      ew = (c >= 2 && c <= 5);
      vectors++;
      if (dst_wren !== ew) begin
        miscompares++;
        $display("FAIL basic_wren c%0d: got %b exp %b", c, dst_wren, ew);
      end
      if (ew) begin
        vectors++;
        if (dst_addr !== 16'h2000 + 16'(c - 2) || dst_data !== ed[c-2]) begin
          miscompares++;
          $display("FAIL basic_write c%0d: got %h=%h exp %h=%h", c, dst_addr, dst_data,
                   16'h2000 + 16'(c - 2), ed[c-2]);
        end
      end
      vectors++;
      if (ans !== (c == 6)) begin
        miscompares++;
        $display("FAIL basic_answer c%0d: got %b exp %b", c, ans, (c == 6));
      end
      if (c < 6) tick();
    end
    vectors++;
    if (ans_w !== 16'd4) begin
      miscompares++;
      $display("FAIL basic_count: got %0d exp 4", ans_w);
    end
    req = 1'b0;
    tick();
    vectors++;
    if (ans !== 1'b0 || ans_w !== 16'd0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_release: got ans=%b ans_w=%h busy=%b exp 0 0 1", ans, ans_w, busy);
    end
    tick();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_idle: got busy=%b exp 0", busy);
    end
  endtask

  task automatic test_zero_count;
    start(16'h1234, 16'h0010, 16'd0);
    for (int c = 1; c <= 3; c++) begin
      vectors++;
      if (ans !== 1'b1 || ans_w !== 16'd0 || dst_wren !== 1'b0) begin
        miscompares++;
        $display("FAIL zero_answer c%0d: got ans=%b ans_w=%h wren=%b exp 1 0 0", c, ans, ans_w, dst_wren);
      end
      tick();
    end
    req = 1'b0;
    tick();
    vectors++;
    if (ans !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_release: got ans=%b busy=%b exp 0 1", ans, busy);
    end
    tick();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_idle: got busy=%b exp 0", busy);
    end
  endtask

  task automatic test_clamp;
    logic [15:0] ed [2];
    int          nw;
    mem[10'h3FE] = 16'h1111;
    mem[10'h3FF] = 16'h2222;
    ed = '{16'h1111, 16'h2222};
    nw = 0;
    start(16'h0100, 16'h03FE, 16'd8);
    for (int c = 1; c <= 4; c++) begin
      logic ew;
      ew = (c >= 2 && c <= 3);
      if (dst_wren) nw++;
      vectors++;
      if (dst_wren !== ew || (ew && (dst_addr !== 16'h0100 + 16'(c - 2) || dst_data !== ed[c-2]))) begin
        miscompares++;
        $display("FAIL clamp_write c%0d: got wren=%b %h=%h exp wren=%b", c, dst_wren, dst_addr, dst_data, ew);
      end
      if (c < 4) tick();
    end
    vectors++;
    if (ans !== 1'b1 || ans_w !== 16'd2 || nw != 2) begin
      miscompares++;
      $display("FAIL clamp_answer: got ans=%b ans_w=%0d writes=%0d exp 1 2 2", ans, ans_w, nw);
    end
    drop_req();
    mem[10'h020] = 16'h5A5A;
    mem[10'h021] = 16'hA5A5;
    start(16'hFFFF, 16'h0020, 16'd2);
    tick();
    vectors++;
    if (dst_wren !== 1'b1 || dst_addr !== 16'hFFFF || dst_data !== 16'h5A5A) begin
      miscompares++;
      $display("FAIL wrap_first: got wren=%b %h=%h exp 1 ffff=5a5a", dst_wren, dst_addr, dst_data);
    end
    tick();
    vectors++;
    if (dst_wren !== 1'b1 || dst_addr !== 16'h0000 || dst_data !== 16'hA5A5) begin
      miscompares++;
      $display("FAIL wrap_second: got wren=%b %h=%h exp 1 0000=a5a5", dst_wren, dst_addr, dst_data);
    end
    tick();
    vectors++;
    if (ans !== 1'b1 || ans_w !== 16'd2 || dst_wren !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_answer: got ans=%b ans_w=%0d wren=%b exp 1 2 0", ans, ans_w, dst_wren);
    end
    drop_req();
    start(16'h0000, 16'h0400, 16'd5);
    vectors++;
    if (ans !== 1'b1 || ans_w !== 16'd0 || dst_wren !== 1'b0) begin
      miscompares++;
      $display("FAIL beyond_depth: got ans=%b ans_w=%0d wren=%b exp 1 0 0", ans, ans_w, dst_wren);
    end
    drop_req();
  endtask

  task automatic test_drop_early;
    for (int k = 0; k < 6; k++) mem[10'h040 + k] = 16'h4000 + 16'(k);
    start(16'h3000, 16'h0040, 16'd6);
    for (int c = 1; c <= 9; c++) begin
      logic ew;
      ew = (c >= 2 && c <= 7);
      vectors++;
      if (dst_wren !== ew || (ew && (dst_addr !== 16'h3000 + 16'(c - 2) || dst_data !== 16'h4000 + 16'(c - 2)))) begin
        miscompares++;
        $display("FAIL drop_write c%0d: got wren=%b %h=%h exp wren=%b", c, dst_wren, dst_addr, dst_data, ew);
      end
      vectors++;
      if (ans !== 1'b0 || busy !== (c <= 7)) begin
        miscompares++;
        $display("FAIL drop_state c%0d: got ans=%b busy=%b exp 0 %b", c, ans, busy, (c <= 7));
      end
      if (c == 2) req = 1'b0;
      tick();
    end
    start(16'h0050, 16'h0010, 16'd1);
    tick();
    vectors++;
    if (dst_wren !== 1'b1 || dst_addr !== 16'h0050 || dst_data !== 16'hAAAA) begin
      miscompares++;
      $display("FAIL after_drop_write: got wren=%b %h=%h exp 1 0050=aaaa", dst_wren, dst_addr, dst_data);
    end
    tick();
    vectors++;
    if (ans !== 1'b1 || ans_w !== 16'd1) begin
      miscompares++;
      $display("FAIL after_drop_answer: got ans=%b ans_w=%0d exp 1 1", ans, ans_w);
    end
    drop_req();
  endtask

  task automatic test_async_reset;
    start(16'h0200, 16'h0010, 16'd8);
    tick();
    tick();
    vectors++;
    if (dst_wren !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_copy: got wren=%b busy=%b exp 1 1", dst_wren, busy);
    end
    req = 1'b0;
    #2;
    clr_n = 1'b0;
    #1;
    vectors++;
    if ({ans, ans_w, src_addr, dst_addr, dst_data, dst_wren, busy} !== '0) begin
      miscompares++;
      $display("FAIL async_reset: got ans=%b src=%h dst=%h data=%h wren=%b busy=%b exp all 0",
               ans, src_addr, dst_addr, dst_data, dst_wren, busy);
    end
    #3;
    clr_n = 1'b1;
    tick();
    vectors++;
    if (busy !== 1'b0 || dst_wren !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_idle: got busy=%b wren=%b exp 0 0", busy, dst_wren);
    end
    start(16'h0010, 16'h0012, 16'd2);
    tick();
    vectors++;
    if (dst_wren !== 1'b1 || dst_addr !== 16'h0010 || dst_data !== 16'hCCCC) begin
      miscompares++;
      $display("FAIL post_reset_w0: got wren=%b %h=%h exp 1 0010=cccc", dst_wren, dst_addr, dst_data);
    end
    tick();
    vectors++;
    if (dst_wren !== 1'b1 || dst_addr !== 16'h0011 || dst_data !== 16'hDDDD) begin
      miscompares++;
      $display("FAIL post_reset_w1: got wren=%b %h=%h exp 1 0011=dddd", dst_wren, dst_addr, dst_data);
    end
    tick();
    vectors++;
    if (ans !== 1'b1 || ans_w !== 16'd2) begin
      miscompares++;
      $display("FAIL post_reset_answer: got ans=%b ans_w=%0d exp 1 2", ans, ans_w);
    end
    drop_req();
  endtask

  task automatic test_read_lat3;
    logic [15:0] ed [3];
    ed = '{16'h6060, 16'h6161, 16'h6262};
    for (int k = 0; k < 3; k++) mem[10'h060 + k] = ed[k];
    where3 = 16'h0700;
    what3  = 16'h0060;
    count3 = 16'd3;
    req3   = 1'b1;
    tick();
    for (int c = 1; c <= 7; c++) begin
      logic ew;
      ew = (c >= 4 && c <= 6);
      vectors++;
      if (dst_wren3 !== ew || (ew && (dst_addr3 !== 16'h0700 + 16'(c - 4) || dst_data3 !== ed[c-4]))) begin
        miscompares++;
        $display("FAIL lat3_write c%0d: got wren=%b %h=%h exp wren=%b", c, dst_wren3, dst_addr3, dst_data3, ew);
      end
      vectors++;
      if (ans3 !== (c == 7)) begin
        miscompares++;
        $display("FAIL lat3_answer c%0d: got %b exp %b", c, ans3, (c == 7));
      end
      if (c == 2) begin
        where3 = 16'h1234;
        what3  = 16'h0000;
        count3 = 16'd1;
      end
      if (c < 7) tick();
    end
    vectors++;
    if (ans_w3 !== 16'd3) begin
      miscompares++;
      $display("FAIL lat3_count: got %0d exp 3", ans_w3);
    end
    req3 = 1'b0;
    tick();
    tick();
    vectors++;
    if (busy3 !== 1'b0 || ans3 !== 1'b0) begin
      miscompares++;
      $display("FAIL lat3_idle: got busy=%b ans=%b exp 0 0", busy3, ans3);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'(i) ^ 16'h0F0F;
    mem[10'h010] = 16'hAAAA;
    mem[10'h011] = 16'hBBBB;
    mem[10'h012] = 16'hCCCC;
    mem[10'h013] = 16'hDDDD;
    test_reset();
    test_basic();
    test_zero_count();
    test_clamp();
    test_drop_early();
    test_async_reset();
    test_read_lat3();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
